// File: rtl/adcfifo_rd_ctrl.sv
// Read-side controller for the ADC sample FIFO: issues RAM reads, tracks read latency and
// streams returned words through a small skid FIFO. Define ADCFIFO_RD_LEVEL_EN to add level_o.
module adcfifo_rd_ctrl #(
    parameter int RWIDTH = 32,
    parameter int AWIDTH = 7,
    parameter int PIPE   = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic [AWIDTH:0]   wptr_i,
    input  logic              flush_i,
    output logic [AWIDTH-1:0] raddr_o,
    output logic              ren_o,
    input  logic [RWIDTH-1:0] rdata_i,
    output logic [AWIDTH:0]   rptr_o,
    output logic [RWIDTH-1:0] dout_o,
    output logic              dvalid_o,
    input  logic              dready_i,
    output logic              empty_o
`ifdef ADCFIFO_RD_LEVEL_EN
    ,
    output logic [AWIDTH:0]   level_o
`endif
);

    localparam int LAT  = 1 + PIPE;
    localparam int SKID = 2 + PIPE;
    localparam int CW   = $clog2(2 * SKID + 1);
    localparam int PW   = (SKID > 1) ? $clog2(SKID) : 1;

    localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

    logic [AWIDTH:0]   rptr_q, rptr_d;
    logic [LAT-1:0]    inflight_q, inflight_d;
    logic [RWIDTH-1:0] skid_mem_q [SKID];
    logic [PW-1:0]     skid_wr_q, skid_wr_d;
    logic [PW-1:0]     skid_rd_q, skid_rd_d;
    logic [CW-1:0]     skid_cnt_q, skid_cnt_d;

    logic [CW-1:0]     inflight_cnt;
    logic [CW-1:0]     credit;
    logic              empty;
    logic              pop;
    logic              push;
    logic              ren;

    function automatic logic [PW-1:0] skidPtrNext(input logic [PW-1:0] p);
        return (p == PW'(SKID - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight_cnt = inflight_cnt + CW'(inflight_q[i]);
        end
    end

    // Credit counts every word that will land in the skid buffer; a pop this cycle frees
    // one slot early so the stream can sustain one word per cycle.
    assign empty  = (rptr_q == wptr_i);
    assign pop    = dvalid_o & dready_i;
    assign push   = inflight_q[LAT-1];
    assign credit = skid_cnt_q + inflight_cnt;
    assign ren    = !reset_i && !empty && !flush_i && ((credit - CW'(pop)) < CW'(SKID));

    always_comb begin
        rptr_d     = rptr_q;
        inflight_d = inflight_q;
        skid_wr_d  = skid_wr_q;
        skid_rd_d  = skid_rd_q;
        skid_cnt_d = skid_cnt_q;
        if (flush_i) begin
            rptr_d     = wptr_i;
            inflight_d = '0;
            skid_wr_d  = '0;
            skid_rd_d  = '0;
            skid_cnt_d = '0;
        end else begin
            if (ren) begin
                rptr_d = rptr_q + PTR_ONE;
            end
            inflight_d[0] = ren;
            for (int i = 1; i < LAT; i++) begin
                inflight_d[i] = inflight_q[i-1];
            end
            if (push) begin
                skid_wr_d = skidPtrNext(skid_wr_q);
            end
            if (pop) begin
                skid_rd_d = skidPtrNext(skid_rd_q);
            end
            skid_cnt_d = skid_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rptr_q     <= '0;
            inflight_q <= '0;
            skid_wr_q  <= '0;
            skid_rd_q  <= '0;
            skid_cnt_q <= '0;
        end else begin
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
            skid_wr_q  <= skid_wr_d;
            skid_rd_q  <= skid_rd_d;
            skid_cnt_q <= skid_cnt_d;
        end
    end

    // Storage needs no reset: a slot is only visible once the occupancy count covers it.
    always_ff @(posedge clock_i) begin
        if (push) begin
            skid_mem_q[skid_wr_q] <= rdata_i;
        end
    end

    assign dvalid_o = (skid_cnt_q != '0);
    assign dout_o   = dvalid_o ? skid_mem_q[skid_rd_q] : '0;
    assign raddr_o  = rptr_q[AWIDTH-1:0];
    assign rptr_o   = rptr_q;
    assign ren_o    = ren;
    assign empty_o  = empty;

`ifdef ADCFIFO_RD_LEVEL_EN
    logic [AWIDTH:0] level_q, level_d;

    assign level_d = wptr_i - rptr_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
`endif

endmodule

// File: tb/tb_adcfifo_rd_ctrl.sv
// Directed bench for adcfifo_rd_ctrl (PIPE=1): a cycle table for the basic stream, then
// hand-written sequences for stall, pointer wrap, flush and mid-read reset.
module tb_adcfifo_rd_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  wptr;
    logic        flush;
    logic [6:0]  raddr;
    logic        ren;
    logic [31:0] rdata;
    logic [7:0]  rptr;
    logic [31:0] dout;
    logic        dvalid;
    logic        dready;
    logic        empty;
`ifdef ADCFIFO_RD_LEVEL_EN
    logic [7:0]  level;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [128];
    logic [31:0] ramQ1;
    logic [31:0] ramQ2;
    logic [6:0]  renLog[$];
    logic [31:0] outLog[$];

    typedef struct {
        logic [7:0]  wptr;
        logic        dready;
        logic        flush;
        logic        expRen;
        logic        expEmpty;
        logic        expDvalid;
        logic [31:0] expDout;
        logic [7:0]  expRptr;
    } vec_t;

    vec_t vecs[9];

    adcfifo_rd_ctrl #(.RWIDTH(32), .AWIDTH(7), .PIPE(1)) dut (
        .clock_i  (clock),
        .reset_i  (reset),
        .wptr_i   (wptr),
        .flush_i  (flush),
        .raddr_o  (raddr),
        .ren_o    (ren),
        .rdata_i  (rdata),
        .rptr_o   (rptr),
        .dout_o   (dout),
        .dvalid_o (dvalid),
        .dready_i (dready),
        .empty_o  (empty)
`ifdef ADCFIFO_RD_LEVEL_EN
        ,
        .level_o  (level)
`endif
    );

    always #5 clock = ~clock;

    // Two-cycle RAM model matching PIPE=1.
    always @(posedge clock) begin
        if (ren) begin
            ramQ1 <= ram[raddr];
        end
        ramQ2 <= ramQ1;
    end
    assign rdata = ramQ2;

    always @(negedge clock) begin
        if (!reset) begin
            if (ren) renLog.push_back(raddr);
            if (dvalid && dready) outLog.push_back(dout);
        end
    end

    task automatic applyStimulus(input logic [7:0] w, input logic dr, input logic fl);
        @(posedge clock);
        #1;
        wptr   = w;
        dready = dr;
        flush  = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 32'hA0 + i;
        ramQ1  = '0;
        ramQ2  = '0;
        reset  = 1'b1;
        wptr   = '0;
        flush  = 1'b0;
        dready = 1'b0;

        //            wptr   drdy  fl    ren   empty dv    dout      rptr
        vecs[0] = '{8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  8'd0};
        vecs[1] = '{8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  8'd0};
        vecs[2] = '{8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  8'd1};
        vecs[3] = '{8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  8'd2};
        vecs[4] = '{8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA0, 8'd3};
        vecs[5] = '{8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA1, 8'd4};
        vecs[6] = '{8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA2, 8'd4};
        vecs[7] = '{8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA3, 8'd4};
        vecs[8] = '{8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  8'd4};

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].wptr, vecs[i].dready, vecs[i].flush);
            checkOutput($sformatf("v%0d.ren", i), 32'(ren), 32'(vecs[i].expRen));
            checkOutput($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].expEmpty));
            checkOutput($sformatf("v%0d.dvalid", i), 32'(dvalid), 32'(vecs[i].expDvalid));
            checkOutput($sformatf("v%0d.dout", i), dout, vecs[i].expDout);
            checkOutput($sformatf("v%0d.rptr", i), 32'(rptr), 32'(vecs[i].expRptr));
            checkOutput($sformatf("v%0d.raddr", i), 32'(raddr), 32'(vecs[i].expRptr[6:0]));
        end

        // Stall: ten words pending, consumer not ready.
        renLog.delete();
        outLog.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'd14, 1'b0, 1'b0);
            if (i >= 3) begin
                checkOutput($sformatf("stall%0d.dvalid", i), 32'(dvalid), 32'd1);
                checkOutput($sformatf("stall%0d.dout", i), dout, 32'hA4);
            end
        end
        checkOutput("stall.renCount", renLog.size(), 32'd3);
        for (int i = 0; i < renLog.size() && i < 3; i++)
            checkOutput($sformatf("stall.raddr%0d", i), 32'(renLog[i]), 32'(4 + i));
        checkOutput("stall.rptr", 32'(rptr), 32'd7);
        for (int i = 0; i < 20; i++) applyStimulus(8'd14, 1'b1, 1'b0);
        checkOutput("drain.count", outLog.size(), 32'd10);
        for (int i = 0; i < outLog.size() && i < 10; i++)
            checkOutput($sformatf("drain.word%0d", i), outLog[i], 32'hA4 + i);
        checkOutput("drain.rptr", 32'(rptr), 32'd14);
        checkOutput("drain.empty", 32'(empty), 32'd1);

        // Wrap: park the read pointer at 126 via flush, then read across the boundary.
        applyStimulus(8'd126, 1'b1, 1'b1);
        checkOutput("wrapFlush.ren", 32'(ren), 32'd0);
        renLog.delete();
        outLog.delete();
        for (int i = 0; i < 12; i++) applyStimulus(8'd130, 1'b1, 1'b0);
        checkOutput("wrap.renCount", renLog.size(), 32'd4);
        checkOutput("wrap.wordCount", outLog.size(), 32'd4);
        for (int i = 0; i < renLog.size() && i < 4; i++)
            checkOutput($sformatf("wrap.raddr%0d", i), 32'(renLog[i]), 32'((126 + i) % 128));
        for (int i = 0; i < outLog.size() && i < 4; i++)
            checkOutput($sformatf("wrap.word%0d", i), outLog[i], 32'hA0 + ((126 + i) % 128));
        checkOutput("wrap.rptr", 32'(rptr), 32'd130);
        checkOutput("wrap.empty", 32'(empty), 32'd1);

        // Flush with two reads in flight and five words still pending.
        renLog.delete();
        outLog.delete();
        applyStimulus(8'd137, 1'b0, 1'b0);
        checkOutput("flushS1.ren", 32'(ren), 32'd1);
        applyStimulus(8'd137, 1'b0, 1'b0);
        checkOutput("flushS2.ren", 32'(ren), 32'd1);
        applyStimulus(8'd137, 1'b0, 1'b1);
        checkOutput("flushS3.ren", 32'(ren), 32'd0);
        applyStimulus(8'd137, 1'b1, 1'b0);
        checkOutput("flushS4.dvalid", 32'(dvalid), 32'd0);
        checkOutput("flushS4.rptr", 32'(rptr), 32'd137);
        checkOutput("flushS4.empty", 32'(empty), 32'd1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'd137, 1'b1, 1'b0);
            checkOutput($sformatf("flushQuiet%0d.dvalid", i), 32'(dvalid), 32'd0);
        end
        checkOutput("flush.staleWords", outLog.size(), 32'd0);
        for (int i = 0; i < 10; i++) applyStimulus(8'd139, 1'b1, 1'b0);
        checkOutput("postFlush.count", outLog.size(), 32'd2);
        for (int i = 0; i < outLog.size() && i < 2; i++)
            checkOutput($sformatf("postFlush.word%0d", i), outLog[i], 32'hA9 + i);

        // Reset one cycle after a read is issued; the returning word must be dropped.
        outLog.delete();
        applyStimulus(8'd140, 1'b1, 1'b0);
        checkOutput("rstR1.ren", 32'(ren), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        wptr  = 8'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rstRel.ren", 32'(ren), 32'd0);
        checkOutput("rstRel.rptr", 32'(rptr), 32'd0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'd0, 1'b1, 1'b0);
            checkOutput($sformatf("rstQuiet%0d.dvalid", i), 32'(dvalid), 32'd0);
        end
        checkOutput("rst.dout", dout, 32'h0);
        checkOutput("rst.empty", 32'(empty), 32'd1);
        checkOutput("rst.staleWords", outLog.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
